store_buffer: RTL and testbench



---
 rtl/store_buffer_pkg.sv | 13 +
 rtl/sb_match.sv | 36 +++
 rtl/store_buffer.sv | 106 ++++++++++
 tb/tb_store_buffer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared sizing and entry type for the MEM-stage store buffer.
package store_buffer_pkg;
  localparam int DW    = 16;
  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } sb_entry_t;
endpackage

// File: rtl/sb_match.sv
// Youngest-match search over the occupied store buffer entries.
// STORE_BUFFER_FWD_EN adds the forwarded data path.
module sb_match
  import store_buffer_pkg::*;
(
  input  logic [DEPTH-1:0][AW-1:0] entry_addr,
`ifdef STORE_BUFFER_FWD_EN
  input  logic [DEPTH-1:0][DW-1:0] entry_data,
  output logic [DW-1:0]            fwd_data,
`endif
  input  logic [PTR_W-1:0]         head,
  input  logic [CNT_W-1:0]         count,
  input  logic [AW-1:0]            ld_addr,
  output logic                     hit
);

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit = 1'b0;
`ifdef STORE_BUFFER_FWD_EN
    fwd_data = '0;
`endif
    idx = head;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (entry_addr[idx] == ld_addr)) begin
        hit = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        fwd_data = entry_data[idx];
`endif
      end
      idx = idx + 1'b1;
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store queue in front of the single-port data memory.
// Define STORE_BUFFER_FWD_EN for store-to-load forwarding; otherwise hitting loads stall.
module store_buffer
  import store_buffer_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  output logic          st_ready,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  output logic [DW-1:0] ld_data,
  output logic          ld_stall,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  output logic          empty
);

  sb_entry_t               entries [DEPTH];
  logic [PTR_W-1:0]        head, tail;
  logic [CNT_W-1:0]        count;
  logic                    full, enq, drain, hit;
  logic [DEPTH-1:0][AW-1:0] entry_addr;
`ifdef STORE_BUFFER_FWD_EN
  logic [DEPTH-1:0][DW-1:0] entry_data;
  logic [DW-1:0]            fwd_data;
`endif

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_addr[i] = entries[i].addr;
`ifdef STORE_BUFFER_FWD_EN
      entry_data[i] = entries[i].data;
`endif
    end
  end

  sb_match u_match (
    .entry_addr (entry_addr),
`ifdef STORE_BUFFER_FWD_EN
    .entry_data (entry_data),
    .fwd_data   (fwd_data),
`endif
    .head       (head),
    .count      (count),
    .ld_addr    (ld_addr),
    .hit        (hit)
  );

  // Draining is suppressed during reset so discarded stores never reach memory.
  always_comb begin
    full     = (count == CNT_W'(DEPTH));
    empty    = (count == '0);
    st_ready = !full;
    enq      = st_valid && !full;
    drain    = !reset && !empty && (!ld_valid || hit || full);

    mem_addr  = ld_addr;
    mem_wdata = '0;
    mem_wr    = 1'b0;
    if (drain) begin
      mem_addr  = entries[head].addr;
      mem_wdata = entries[head].data;
      mem_wr    = 1'b1;
    end

    ld_data  = '0;
    ld_stall = 1'b0;
    if (ld_valid) begin
      if (st_valid) begin
        ld_stall = 1'b1;
      end else if (hit) begin
`ifdef STORE_BUFFER_FWD_EN
        ld_data = fwd_data;
`else
        ld_stall = 1'b1;
`endif
      end else if (drain) begin
        ld_stall = 1'b1;
      end else begin
        ld_data = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq)   tail <= tail + 1'b1;
      if (drain) head <= head + 1'b1;
      count <= count + CNT_W'(enq) - CNT_W'(drain);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) entries[tail] <= '{addr: st_addr, data: st_data};
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model plus directed scenarios.
module tb_store_buffer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        st_valid = 1'b0;
  logic [4:0]  st_addr = '0;
  logic [15:0] st_data = '0;
  logic        st_ready;
  logic        ld_valid = 1'b0;
  logic [4:0]  ld_addr = '0;
  logic [15:0] ld_data;
  logic        ld_stall;
  logic [4:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_wr;
  logic [15:0] mem_rdata;
  logic        empty;

  int checks = 0;
  int errors = 0;

  store_buffer dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_stall(ld_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
    .empty(empty)
  );

  always #5 clk = ~clk;

  // Data memory the DUT drives.
  logic [15:0] mem [32];
  bit          mem_loaded = 1'b0;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 32; i++) mem[i] <= 16'hC000 + 16'(i);
      mem_loaded <= 1'b1;
    end else if (mem_wr === 1'b1) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of pending stores and the memory image it implies.
  typedef struct packed { logic [4:0] a; logic [15:0] d; } ent_t;
  ent_t        q[$];
  logic [15:0] mmem [32];
  bit          started = 1'b0;
  int          n;
  bit          e_full, e_empty, e_hit, e_drain, e_stall;
  logic [15:0] e_fwd, e_ld;

  always @(negedge clk) begin
    if (!started) begin
      if (reset === 1'b1) begin
        for (int i = 0; i < 32; i++) mmem[i] = 16'hC000 + 16'(i);
        q.delete();
        started = 1'b1;
      end
    end else begin
      n       = q.size();
      e_full  = (n == 4);
      e_empty = (n == 0);
      e_hit   = 1'b0;
      e_fwd   = '0;
      for (int i = 0; i < n; i++)
        if (q[i].a == ld_addr) begin e_hit = 1'b1; e_fwd = q[i].d; end
      e_drain = !reset && !e_empty && (!ld_valid || e_hit || e_full);
      e_stall = 1'b0;
      e_ld    = '0;
      if (ld_valid) begin
        if (st_valid) e_stall = 1'b1;
        else if (e_hit) begin
`ifdef STORE_BUFFER_FWD_EN
          e_ld = e_fwd;
`else
          e_stall = 1'b1;
`endif
        end
        else if (e_drain) e_stall = 1'b1;
        else e_ld = mmem[ld_addr];
      end

      chk("st_ready", st_ready, !e_full);
      chk("empty", empty, e_empty);
      chk("mem_wr", mem_wr, e_drain);
      chk("mem_addr", mem_addr, e_drain ? q[0].a : ld_addr);
      chk("mem_wdata", mem_wdata, e_drain ? q[0].d : 16'h0);
      chk("ld_stall", ld_stall, e_stall);
      if (ld_valid && (!e_stall || st_valid)) chk("ld_data", ld_data, e_ld);

      if (reset) q.delete();
      else begin
        if (e_drain) begin
          mmem[q[0].a] = q[0].d;
          void'(q.pop_front());
        end
        if (st_valid && !e_full) q.push_back({st_addr, st_data});
      end
    end
  end

  task automatic step(input bit r, input bit sv, input logic [4:0] sa, input logic [15:0] sd,
                      input bit lv, input logic [4:0] la);
    @(posedge clk); #1;
    reset = r; st_valid = sv; st_addr = sa; st_data = sd; ld_valid = lv; ld_addr = la;
    @(negedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0);
  endtask

  int  stalls;
  bit  got;

  initial begin
    step(1'b1, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0);
    step(1'b1, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0);
    idle();
    chk("rst_st_ready", st_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_ld_stall", ld_stall, 0);

    // single store then idle
    step(1'b0, 1'b1, 5'd3, 16'h00AA, 1'b0, 5'd0);
    idle();
    chk("single_wr", mem_wr, 1);
    chk("single_addr", mem_addr, 3);
    idle();
    chk("single_mem3", mem[3], 16'h00AA);
    chk("single_empty", empty, 1);

    // fill while a non-hitting load is held
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 5'(4 + i), 16'h0040 + 16'(i), 1'b1, 5'd0);
    step(1'b0, 1'b0, 5'd0, 16'h0, 1'b1, 5'd0);
    chk("full_st_ready", st_ready, 0);
    chk("full_ld_stall", ld_stall, 1);
    chk("full_drain_addr", mem_addr, 4);
    step(1'b0, 1'b0, 5'd0, 16'h0, 1'b1, 5'd0);
    chk("after_full_stall", ld_stall, 0);
    chk("after_full_data", ld_data, 16'hC000);
    repeat (4) idle();

    // two stores to the same address, then a load of it
    step(1'b0, 1'b1, 5'd2, 16'h0005, 1'b0, 5'd0);
    step(1'b0, 1'b1, 5'd2, 16'h0009, 1'b0, 5'd0);
    stalls = 0;
    got    = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      step(1'b0, 1'b0, 5'd0, 16'h0, 1'b1, 5'd2);
      if (ld_stall === 1'b0) got = 1'b1;
      else stalls++;
    end
    chk("fwd_done", got, 1);
    chk("fwd_data", ld_data, 16'h0009);
`ifdef STORE_BUFFER_FWD_EN
    chk("fwd_stalls", stalls, 0);
`else
    chk("fwd_stalls", stalls, 1);
`endif
    repeat (3) idle();

    // wrap-around: ten stores with occasional idle cycles
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 5'(i), 16'h0100 + 16'(i), 1'b0, 5'd0);
      if (i % 3 == 2) idle();
    end
    repeat (5) idle();
    for (int i = 0; i < 10; i++) chk($sformatf("wrap_mem%0d", i), mem[i], 16'h0100 + 32'(i));

    // reset with three stores pending
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 5'(20 + i), 16'hBEE0 + 16'(i), 1'b1, 5'd31);
    step(1'b1, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0);
    chk("midrst_mem_wr", mem_wr, 0);
    idle();
    chk("midrst_empty", empty, 1);
    chk("midrst_st_ready", st_ready, 1);
    chk("midrst_no_wr", mem_wr, 0);
    idle();
    for (int i = 0; i < 3; i++) chk($sformatf("midrst_mem%0d", 20 + i), mem[20 + i], 16'hC014 + 32'(i));

    // store and load presented together
    step(1'b0, 1'b1, 5'd11, 16'h7777, 1'b1, 5'd11);
    chk("both_stall", ld_stall, 1);
    chk("both_data", ld_data, 0);
    idle();
    chk("both_drain_wr", mem_wr, 1);
    chk("both_drain_addr", mem_addr, 11);
    chk("both_drain_data", mem_wdata, 16'h7777);
    idle();
    chk("both_mem11", mem[11], 16'h7777);
    repeat (2) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
